// File: rtl/wr_ctrl_sync_r2w.sv
// Write-side controller of the dual-clock FIFO: synchronises the Gray read pointer into wrclk,
// owns the write pointer and produces registered full / almost_full / free-count / overflow flags.
module wr_ctrl_sync_r2w #(
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int AFULL_THRESH    = 4
) (
  input  logic                       wrclk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [FIFO_ADDR_WIDTH:0]   rdptr_gray,
  input  logic                       ovf_clr,
  output logic                       mem_we,
  output logic [FIFO_ADDR_WIDTH-1:0] wr_addr,
  output logic [FIFO_ADDR_WIDTH:0]   wrptr_gray,
  output logic                       full,
  output logic                       almost_full,
  output logic [FIFO_ADDR_WIDTH:0]   wr_free,
  output logic                       wr_ovf
);

  localparam int AW = FIFO_ADDR_WIDTH;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH     = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] AFULL_LIM = PW'(AFULL_THRESH);

  logic [SYNC_STAGES-1:0][PW-1:0] sq_reg;
  logic [PW-1:0] rbin;
  logic [PW-1:0] sync_gray;

  logic [PW-1:0] wbin_reg, wbin_next;
  logic [PW-1:0] wrptr_gray_reg, wrptr_gray_next;
  logic [PW-1:0] used;
  logic [PW-1:0] wr_free_reg, wr_free_next;
  logic          full_reg, full_next;
  logic          almost_full_reg, almost_full_next;
  logic          wr_ovf_reg, wr_ovf_next;
  logic          acc;

  // Only sq_reg[0] sees the asynchronous pointer; nothing combinational sits in front of it.
  always_ff @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      sq_reg <= '0;
    end else begin
      sq_reg[0] <= rdptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sq_reg[i] <= sq_reg[i-1];
      end
    end
  end

  assign sync_gray = sq_reg[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign rbin[gi] = ^sync_gray[PW-1:gi];
    end
  endgenerate

  always_comb begin
    acc              = wr_en & ~full_reg;
    wbin_next        = wbin_reg + {{AW{1'b0}}, acc};
    wrptr_gray_next  = wbin_next ^ (wbin_next >> 1);
    used             = wbin_next - rbin;
    // Anything beyond DEPTH is a protocol error and is reported as full.
    full_next        = (used >= DEPTH);
    wr_free_next     = full_next ? '0 : (DEPTH - used);
    almost_full_next = (wr_free_next <= AFULL_LIM);
    wr_ovf_next      = (wr_en & full_reg) | (wr_ovf_reg & ~ovf_clr);
  end

  always_ff @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      wbin_reg        <= '0;
      wrptr_gray_reg  <= '0;
      full_reg        <= 1'b0;
      almost_full_reg <= 1'b0;
      wr_free_reg     <= DEPTH;
      wr_ovf_reg      <= 1'b0;
    end else begin
      wbin_reg        <= wbin_next;
      wrptr_gray_reg  <= wrptr_gray_next;
      full_reg        <= full_next;
      almost_full_reg <= almost_full_next;
      wr_free_reg     <= wr_free_next;
      wr_ovf_reg      <= wr_ovf_next;
    end
  end

  assign mem_we      = acc;
  assign wr_addr     = wbin_reg[AW-1:0];
  assign wrptr_gray  = wrptr_gray_reg;
  assign full        = full_reg;
  assign almost_full = almost_full_reg;
  assign wr_free     = wr_free_reg;
  assign wr_ovf      = wr_ovf_reg;

  // The read domain samples wrptr_gray asynchronously, so it may only ever move by one bit.
  a_gray_one_bit: assert property (@(posedge wrclk) disable iff (!reset_n)
    $countones(wrptr_gray_reg ^ $past(wrptr_gray_reg)) <= 1);

endmodule

// File: tb/tb_wr_ctrl_sync_r2w.sv
// Randomised scoreboard bench for wr_ctrl_sync_r2w: an occupancy model built from write/read
// counts predicts every cycle's outputs, and a separate monitor compares them.
module tb_wr_ctrl_sync_r2w;
  localparam int AW    = 8;
  localparam int S     = 2;
  localparam int DEPTH = 1 << AW;
  localparam int THR   = 4;

  logic          wrclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW:0]   rdptr_gray = '0;
  logic          ovf_clr = 1'b0;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wrptr_gray;
  logic          full, almost_full;
  logic [AW:0]   wr_free;
  logic          wr_ovf;

  wr_ctrl_sync_r2w #(.FIFO_ADDR_WIDTH(AW), .SYNC_STAGES(S), .AFULL_THRESH(THR)) dut (
    .wrclk(wrclk), .reset_n(reset_n), .wr_en(wr_en), .rdptr_gray(rdptr_gray),
    .ovf_clr(ovf_clr), .mem_we(mem_we), .wr_addr(wr_addr), .wrptr_gray(wrptr_gray),
    .full(full), .almost_full(almost_full), .wr_free(wr_free), .wr_ovf(wr_ovf)
  );

  always #5 wrclk = ~wrclk;

  typedef struct {
    bit mem_we; int addr; int gray; bit full; bit af; int free; bit ovf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Model state: unbounded counts of accepted writes and of read-pointer progress.
  int   wr_count, rd_val;
  int   rd_pipe[$];
  bit   m_full, m_ovf;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endfunction

  function automatic void model_reset();
    wr_count = 0; rd_val = 0; m_full = 0; m_ovf = 0;
    rd_pipe.delete();
    for (int i = 0; i < S; i++) rd_pipe.push_back(0);
  endfunction

  // One wrclk cycle of normal operation; entered and left on a falling edge.
  task automatic step(input bit we, input bit clr);
    exp_t e;
    int   rd_seen, used;
    reset_n = 1'b1; wr_en = we; ovf_clr = clr;
    rdptr_gray = (AW+1)'(gray(rd_val % (2*DEPTH)));
    // The read count reaches the occupancy calculation S edges after it is first sampled.
    rd_seen = rd_pipe.pop_front();
    rd_pipe.push_back(rd_val);
    e.mem_we = we && !m_full;
    e.addr   = wr_count % DEPTH;
    m_ovf    = (we && m_full) || (m_ovf && !clr);
    if (e.mem_we) wr_count++;
    used     = wr_count - rd_seen;
    m_full   = (used >= DEPTH);
    e.free   = m_full ? 0 : DEPTH - used;
    e.af     = (e.free <= THR);
    e.full   = m_full;
    e.ovf    = m_ovf;
    e.gray   = gray(wr_count % (2*DEPTH));
    sbq.push_back(e);
    @(negedge wrclk);
  endtask

  task automatic rst_step(input bit we);
    exp_t e;
    reset_n = 1'b0; wr_en = we; ovf_clr = 1'b0; rdptr_gray = '0;
    model_reset();
    e.mem_we = we; e.addr = 0; e.gray = 0; e.full = 0; e.af = 0; e.free = DEPTH; e.ovf = 0;
    sbq.push_back(e);
    @(negedge wrclk);
  endtask

  // Monitor: pre-edge outputs mid-low-phase, registered outputs just after the rising edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge wrclk);
      #2;
      if (sbq.size() > 0) begin
        r = sbq.pop_front();
        chk("mem_we", int'(mem_we), int'(r.mem_we));
        chk("wr_addr", int'(wr_addr), r.addr);
        @(posedge wrclk);
        #1;
        cyc++;
        chk("wrptr_gray", int'(wrptr_gray), r.gray);
        chk("full", int'(full), int'(r.full));
        chk("almost_full", int'(almost_full), int'(r.af));
        chk("wr_free", int'(wr_free), r.free);
        chk("wr_ovf", int'(wr_ovf), int'(r.ovf));
      end
    end
  end

  initial begin
    model_reset();
    @(negedge wrclk);

    // Reset held with a toggling write request.
    for (int i = 0; i < 4; i++) rst_step(1'(i));

    // Fill from empty with the read pointer parked at zero, then overflow and clear.
    for (int i = 0; i < 252; i++) step(1, 0);
    chk("s2_afull_252", int'(almost_full), 1);
    chk("s2_free_252", int'(wr_free), 4);
    for (int i = 0; i < 4; i++) step(1, 0);
    chk("s2_full_256", int'(full), 1);
    chk("s2_free_256", int'(wr_free), 0);
    step(1, 0);
    chk("s2_ovf_set", int'(wr_ovf), 1);
    chk("s2_addr_hold", int'(wr_addr), 0);
    step(0, 1);
    chk("s2_ovf_clr", int'(wr_ovf), 0);

    // Drain visibility: reader frees 16 entries; flags follow after the synchroniser delay.
    rd_val = 16;
    step(0, 0);
    chk("s3_still_full", int'(full), 1);
    for (int i = 0; i < S; i++) step(0, 0);
    chk("s3_full_clear", int'(full), 0);
    chk("s3_free_16", int'(wr_free), 16);

    // Simultaneous write and read-pointer advance leave the free count unchanged.
    rd_val = wr_count - 156;
    for (int i = 0; i < S + 2; i++) step(0, 0);
    chk("s5_free_100", int'(wr_free), 100);
    rd_val++;
    for (int i = 0; i < S; i++) step(0, 0);
    step(1, 0);
    chk("s5_free_same", int'(wr_free), 100);

    // Wrap: the reader trails the writer by ten through pointer wrap-around.
    for (int i = 0; i < 600; i++) begin
      rd_val = wr_count - 10;
      step(1, 0);
    end
    chk("s4_no_full", int'(full), 0);

    // Random traffic with occasional overflow clears.
    for (int i = 0; i < 2000; i++) begin
      if (rd_val < wr_count && $urandom_range(0, 1) == 1) rd_val++;
      step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 400; i++) begin
      if (rd_val < wr_count && $urandom_range(0, 3) == 0) rd_val++;
      step($urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0);
    end

    // Fill up, then clear and overflow in the same cycle: the set wins.
    for (int i = 0; i < 2*DEPTH && !m_full; i++) step(1, 0);
    step(0, 1);
    step(1, 1);
    chk("s5_set_wins", int'(wr_ovf), 1);

    // Mid-run reset at write count 77, then a clean restart from address zero.
    for (int i = 0; i < S + 1; i++) rst_step(0);
    for (int i = 0; i < 77; i++) begin
      if ($urandom_range(0, 1) == 1) rd_val = wr_count;
      step(1, 0);
    end
    chk("s6_addr_77", int'(wr_addr), 77);
    reset_n = 1'b0; wr_en = 1'b1;
    #1;
    chk("s6_async_free", int'(wr_free), DEPTH);
    chk("s6_async_full", int'(full), 0);
    chk("s6_async_afull", int'(almost_full), 0);
    chk("s6_async_ovf", int'(wr_ovf), 0);
    chk("s6_async_gray", int'(wrptr_gray), 0);
    chk("s6_async_addr", int'(wr_addr), 0);
    chk("s6_async_we", int'(mem_we), 1);
    @(negedge wrclk);
    for (int i = 0; i < 3; i++) rst_step(1);
    for (int i = 0; i < 20; i++) begin
      rd_val = wr_count;
      step(1, 0);
    end

    repeat (3) @(negedge wrclk);
    if (sbq.size() != 0) chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
